// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline stage feeding the 32-bit ALU. Each accepted
//   instruction has its operands resolved immediately (x0, forwarding,
//   immediate extension) and is buffered in a 2-entry skid FIFO. The head
//   entry is presented to execute with a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   decode handshake (in_ready = FIFO not full)
//   rs1_addr, rs1_data    source 1 index and register-file data
//   rs2_addr, rs2_data    source 2 index and register-file data
//   imm, use_imm          raw immediate; select it as operand B
//   op_and                1: AND, 0: ADD
//   rd_addr, reg_write    destination and its write enable
//   fwd_valid/_rd/_data   result forwarded from a later stage
//   flush                 synchronous kill of all buffered entries
//   out_valid / out_ready execute handshake
//   alu_a, alu_b, alu_sel ALU operands and op select of the head entry
//   out_rd, out_reg_write destination and write enable of the head entry
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 12,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [IMM_W-1:0]   imm,
    input  logic               use_imm,
    input  logic               op_and,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               reg_write,
    input  logic               fwd_valid,
    input  logic [RADDR_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]    fwd_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic               alu_sel,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_write
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic               sel;
        logic [RADDR_W-1:0] rd;
        logic               rw;
    } entry_t;

    occ_t   state;
    entry_t head_q;     // oldest entry, drives the outputs
    entry_t tail_q;     // second entry, valid only in TWO
    entry_t new_entry;  // incoming instruction with operands resolved
    logic   push;
    logic   pop;

    // x0 reads as zero; a forwarded result beats register-file data. Because
    // x0 is checked first, a forward targeting x0 can never take effect.
    function automatic logic [XLEN-1:0] resolve_src(
        input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0]    rf_data
    );
        if (addr == '0)
            return '0;
        else if (fwd_valid && (fwd_rd == addr))
            return fwd_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        // NOTE: every field gets a value before any condition, so no latch can be inferred.
        new_entry     = '0;
        new_entry.a   = resolve_src(rs1_addr, rs1_data);
        new_entry.sel = op_and;
        new_entry.rd  = rd_addr;
        new_entry.rw  = reg_write;
        if (!use_imm)
            new_entry.b = resolve_src(rs2_addr, rs2_data);
        else if (op_and)
            new_entry.b = {{(XLEN-IMM_W){1'b0}}, imm};           // logical imm: zero-extend
        else
            new_entry.b = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};   // arithmetic imm: sign-extend
    end

    assign in_ready = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Occupancy tracking and entry storage. The head register always holds the
    // oldest entry, so the outputs need no read mux and stay stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both storage entries are reset because the head drives the outputs, which must read zero in reset.
            state  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            // Flush overrides any push or pop presented in the same cycle.
            state <= EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q <= new_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q <= new_entry;
                            state  <= TWO;
                        end
                        2'b01: state <= EMPTY;
                        2'b11: head_q <= new_entry;   // head leaves, newcomer takes its place
                        default: ;
                    endcase
                end
                TWO: begin
                    if (pop) begin
                        head_q <= tail_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign alu_a         = head_q.a;
    assign alu_b         = head_q.b;
    assign alu_sel       = head_q.sel;
    assign out_rd        = head_q.rd;
    // A stale head must never look like a pending register write.
    assign out_reg_write = head_q.rw & out_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, fwd_rd, out_rd;
    logic [31:0] rs1_data, rs2_data, fwd_data, alu_a, alu_b;
    logic [11:0] imm;
    logic        use_imm, op_and, reg_write, fwd_valid, flush;
    logic        out_valid, out_ready, alu_sel, out_reg_write;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .use_imm(use_imm), .op_and(op_and),
        .rd_addr(rd_addr), .reg_write(reg_write),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: a queue of resolved beats ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [4:0]  rd;
        logic        rw;
    } beat_t;

    beat_t q[$];

    function automatic logic [31:0] m_src(input logic [4:0] addr, input logic [31:0] data);
        if (addr == 0) return 32'd0;
        if (fwd_valid && fwd_rd == addr) return fwd_data;
        return data;
    endfunction

    function automatic beat_t m_beat();
        beat_t b;
        b.a   = m_src(rs1_addr, rs1_data);
        if (!use_imm)    b.b = m_src(rs2_addr, rs2_data);
        else if (op_and) b.b = 32'(imm);
        else             b.b = 32'($signed(imm));
        b.sel = op_and;
        b.rd  = rd_addr;
        b.rw  = reg_write;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit had_room;
            beat_t nb;
            had_room = (q.size() < 2);
            nb = m_beat();
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && had_room) q.push_back(nb);
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic idle();
        in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
        imm = 0; use_imm = 0; op_and = 0; rd_addr = 0; reg_write = 0;
        fwd_valid = 0; fwd_rd = 0; fwd_data = 0; flush = 0; out_ready = 0;
    endtask

    task automatic beat(input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic [11:0] im, input logic ui, input logic oa,
                        input logic [4:0] rd, input logic rw);
        in_valid = 1; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
        imm = im; use_imm = ui; op_and = oa; rd_addr = rd; reg_write = rw;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        step(); step();
        checks++;
        if (out_valid !== 0 || alu_a !== 0 || alu_b !== 0 || out_rd !== 0 ||
            alu_sel !== 0 || out_reg_write !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b a=%0h b=%0h rd=%0d sel=%0b rw=%0b expected all 0",
                     out_valid, alu_a, alu_b, out_rd, alu_sel, out_reg_write);
        end
        rst_n = 1;
        step();
        checks++;
        if (in_ready !== 1 || out_valid !== 0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic_add();
        idle();
        beat(5'd3, 32'd10, 5'd4, 32'd20, 12'd0, 0, 0, 5'd7, 1);
        step();
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || alu_a !== 32'd10 || alu_b !== 32'd20 || alu_sel !== 0 ||
            out_rd !== 5'd7 || out_reg_write !== 1) begin
            errors++;
            $display("FAIL basic_add: got v=%0b a=%0d b=%0d sel=%0b rd=%0d rw=%0b expected 1/10/20/0/7/1",
                     out_valid, alu_a, alu_b, alu_sel, out_rd, out_reg_write);
        end
        out_ready = 1;
        step();
        checks++;
        if (out_valid !== 0 || out_reg_write !== 0) begin
            errors++;
            $display("FAIL basic_drain: got out_valid=%0b rw=%0b expected 0/0", out_valid, out_reg_write);
        end
    endtask

    task automatic test_imm_extend();
        idle();
        out_ready = 1;
        beat(5'd1, 32'd5, 5'd2, 32'd6, 12'hFFF, 1, 0, 5'd1, 1);
        step();
        beat(5'd1, 32'd5, 5'd2, 32'd6, 12'hFFF, 1, 1, 5'd2, 1);
        checks++;
        if (out_valid !== 1 || alu_b !== 32'hFFFF_FFFF || alu_sel !== 0) begin
            errors++;
            $display("FAIL imm_sext: got v=%0b b=%0h sel=%0b expected 1/ffffffff/0", out_valid, alu_b, alu_sel);
        end
        step();
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || alu_b !== 32'h0000_0FFF || alu_sel !== 1 || out_rd !== 5'd2) begin
            errors++;
            $display("FAIL imm_zext: got v=%0b b=%0h sel=%0b rd=%0d expected 1/fff/1/2",
                     out_valid, alu_b, alu_sel, out_rd);
        end
        step();
    endtask

    task automatic test_forward();
        idle();
        out_ready = 1;
        beat(5'd5, 32'd1, 5'd6, 32'd2, 12'd0, 0, 0, 5'd9, 1);
        fwd_valid = 1; fwd_rd = 5'd5; fwd_data = 32'd99;
        step();
        beat(5'd0, 32'd55, 5'd6, 32'd2, 12'd0, 0, 0, 5'd9, 1);
        fwd_valid = 1; fwd_rd = 5'd0; fwd_data = 32'd77;
        checks++;
        if (alu_a !== 32'd99 || alu_b !== 32'd2) begin
            errors++;
            $display("FAIL fwd_rs1: got a=%0d b=%0d expected 99/2", alu_a, alu_b);
        end
        step();
        idle();
        out_ready = 1;
        checks++;
        if (out_valid !== 1 || alu_a !== 32'd0) begin
            errors++;
            $display("FAIL fwd_x0: got v=%0b a=%0d expected 1/0", out_valid, alu_a);
        end
        step();
    endtask

    task automatic test_backpressure();
        idle();
        beat(5'd1, 32'd101, 5'd0, 32'd0, 12'd0, 0, 0, 5'd1, 1);
        step();
        beat(5'd2, 32'd102, 5'd0, 32'd0, 12'd0, 0, 0, 5'd2, 1);
        step();
        beat(5'd3, 32'd103, 5'd0, 32'd0, 12'd0, 0, 0, 5'd3, 1);
        checks++;
        if (in_ready !== 0) begin
            errors++;
            $display("FAIL bp_full: got in_ready=%0b expected 0", in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1 || alu_a !== 32'd101 || out_rd !== 5'd1 || in_ready !== 0) begin
                errors++;
                $display("FAIL bp_stall%0d: got v=%0b a=%0d rd=%0d rdy=%0b expected 1/101/1/0",
                         i, out_valid, alu_a, out_rd, in_ready);
            end
        end
        idle();
        out_ready = 1;
        step();
        checks++;
        if (out_valid !== 1 || alu_a !== 32'd102 || out_rd !== 5'd2) begin
            errors++;
            $display("FAIL bp_second: got v=%0b a=%0d rd=%0d expected 1/102/2", out_valid, alu_a, out_rd);
        end
        step();
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL bp_no_third: got out_valid=%0b a=%0d expected 0", out_valid, alu_a);
        end
    endtask

    task automatic test_flush();
        idle();
        beat(5'd1, 32'd201, 5'd0, 32'd0, 12'd0, 0, 0, 5'd1, 1);
        step();
        beat(5'd1, 32'd202, 5'd0, 32'd0, 12'd0, 0, 0, 5'd2, 1);
        step();
        beat(5'd1, 32'd999, 5'd0, 32'd0, 12'd0, 0, 0, 5'd3, 1);
        flush = 1;
        out_ready = 1;
        step();
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_reg_write !== 0) begin
            errors++;
            $display("FAIL flush_two: got v=%0b rdy=%0b rw=%0b expected 0/1/0", out_valid, in_ready, out_reg_write);
        end
        // Flush with one entry and a simultaneous push: push must be dropped.
        flush = 0;
        out_ready = 0;
        beat(5'd1, 32'd301, 5'd0, 32'd0, 12'd0, 0, 0, 5'd4, 1);
        step();
        beat(5'd1, 32'd888, 5'd0, 32'd0, 12'd0, 0, 0, 5'd5, 1);
        flush = 1;
        step();
        idle();
        out_ready = 1;
        step();
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL flush_push_dropped: got out_valid=%0b a=%0d expected 0", out_valid, alu_a);
        end
    endtask

    task automatic test_async_reset();
        idle();
        beat(5'd1, 32'h1234, 5'd2, 32'h5678, 12'd0, 0, 1, 5'd6, 1);
        step();
        idle();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 0 || alu_a !== 0 || alu_b !== 0 || alu_sel !== 0 ||
            out_rd !== 0 || out_reg_write !== 0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b a=%0h b=%0h sel=%0b rd=%0d rw=%0b expected all 0",
                     out_valid, alu_a, alu_b, alu_sel, out_rd, out_reg_write);
        end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_random();
        beat_t h;
        logic  exp_rw;
        idle();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            rs1_addr  = 5'($urandom_range(0, 3));
            rs2_addr  = 5'($urandom_range(0, 3));
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            imm       = 12'($urandom);
            use_imm   = $urandom_range(0, 1);
            op_and    = $urandom_range(0, 1);
            rd_addr   = 5'($urandom);
            reg_write = $urandom_range(0, 1);
            fwd_valid = $urandom_range(0, 1);
            fwd_rd    = 5'($urandom_range(0, 3));
            fwd_data  = $urandom;
            step();
            checks++;
            if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got rdy=%0b v=%0b expected count %0d", i, in_ready, out_valid, q.size());
            end
            exp_rw = 1'b0;
            if (q.size() != 0) begin
                h = q[0];
                exp_rw = h.rw;
                checks++;
                if (alu_a !== h.a || alu_b !== h.b || alu_sel !== h.sel || out_rd !== h.rd) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got a=%0h b=%0h sel=%0b rd=%0d expected a=%0h b=%0h sel=%0b rd=%0d",
                             i, alu_a, alu_b, alu_sel, out_rd, h.a, h.b, h.sel, h.rd);
                end
            end
            checks++;
            if (out_reg_write !== exp_rw) begin
                errors++;
                $display("FAIL rand_rw[%0d]: got %0b expected %0b", i, out_reg_write, exp_rw);
            end
        end
        idle();
        out_ready = 1;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_imm_extend();
        test_forward();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
